// File: rtl/steer_en_ctrl_if.sv
// Load-cell sample bus and rider/steer status for steer_en_ctrl.
// master: drives lft_ld, rght_ld, ld_vld; receives en_steer, rider_off, sm_state.
// slave : receives the samples; drives the status outputs.
//   lft_ld    [LD_W] left load-cell sample, unsigned
//   rght_ld   [LD_W] right load-cell sample, unsigned
//   ld_vld    [1]    one-cycle strobe marking new samples
//   en_steer  [1]    steering enable to balance control
//   rider_off [1]    no rider present
//   sm_state  [2]    state code (IDLE=0, WAIT=1, STEER=2)
interface steer_en_ctrl_if #(
    parameter int unsigned LD_W = 12
);
    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            ld_vld;
    logic            en_steer;
    logic            rider_off;
    logic [1:0]      sm_state;

    modport master (
        output lft_ld, rght_ld, ld_vld,
        input  en_steer, rider_off, sm_state
    );

    modport slave (
        input  lft_ld, rght_ld, ld_vld,
        output en_steer, rider_off, sm_state
    );
endinterface

// File: rtl/steer_en_ctrl.sv
// Rider-detect / steering-enable controller. Registers weight and balance
// flags on each load-cell strobe and runs an IDLE/WAIT/STEER state machine
// that enables steering once a balanced rider has settled for TMR_CYCLES.
// Ports:
//   clk   : 50 MHz clock, the only clock
//   rst_n : asynchronous active-low reset
//   bus   : steer_en_ctrl_if.slave (lft_ld, rght_ld, ld_vld in;
//           en_steer, rider_off, sm_state out, decoded from the state register)
// Build option: define STEP_OFF_DLY_EN to require STEP_OFF_CYCLES consecutive
// clocks of severe imbalance before leaving STEER; undefined leaves on the
// first such clock.
module steer_en_ctrl #(
    parameter int unsigned LD_W            = 12,
    parameter int unsigned MIN_RIDER_WT    = 32'h0000_0200,
    parameter int unsigned HYST            = 32'h0000_0040,
    parameter int unsigned TMR_CYCLES      = 65_000_000,
    parameter int unsigned STEP_OFF_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    steer_en_ctrl_if.slave bus
);

    localparam int unsigned SUM_W    = LD_W + 1;
    localparam int unsigned TMR_W    = (TMR_CYCLES > 1) ? $clog2(TMR_CYCLES) : 1;
    localparam int unsigned HI_THR   = MIN_RIDER_WT + HYST;
    // Lower threshold only exists when MIN_RIDER_WT-HYST is non-negative.
    localparam bit          LO_VALID = (MIN_RIDER_WT >= HYST);
    localparam int unsigned LO_THR   = LO_VALID ? (MIN_RIDER_WT - HYST) : 0;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TMR_CYCLES - 1);

    // Zero-length timers would underflow the terminal counts.
    if (TMR_CYCLES == 0 || STEP_OFF_CYCLES == 0) begin : g_bad_param
        $error("steer_en_ctrl: TMR_CYCLES and STEP_OFF_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2
    } state_t;

    typedef struct packed {
        logic sum_gt_min;
        logic sum_lt_min;
        logic diff_gt_1_4;
        logic diff_gt_15_16;
    } flags_t;

    state_t           state_q, state_d;
    flags_t           flags_q, flags_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic [SUM_W-1:0] sum_c;
    logic [LD_W-1:0]  diff_c;
    logic             tmr_full_c;
    logic             clr_tmr_c;
    logic             step_off_c;

    // Sum at full width so two full-scale samples cannot wrap.
    assign sum_c  = SUM_W'(bus.lft_ld) + SUM_W'(bus.rght_ld);
    assign diff_c = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                                : (bus.rght_ld - bus.lft_ld);

    // Flags update only on a strobe and hold between samples.
    always_comb begin
        flags_d = flags_q;
        if (bus.ld_vld) begin
            flags_d.sum_gt_min    = (32'(sum_c) > HI_THR);
            flags_d.sum_lt_min    = LO_VALID && (32'(sum_c) < LO_THR);
            flags_d.diff_gt_1_4   = (SUM_W'(diff_c) > (sum_c >> 2));
            flags_d.diff_gt_15_16 = (SUM_W'(diff_c) > (sum_c - (sum_c >> 4)));
        end
    end

    assign tmr_full_c = (tmr_q == TMR_MAX);

`ifdef STEP_OFF_DLY_EN
    localparam int unsigned SO_W = (STEP_OFF_CYCLES > 1) ? $clog2(STEP_OFF_CYCLES + 1) : 1;
    localparam logic [SO_W-1:0] SO_MAX = SO_W'(STEP_OFF_CYCLES - 1);

    logic [SO_W-1:0] so_q, so_d;

    // Counts consecutive STEER clocks with severe imbalance.
    always_comb begin
        so_d = so_q;
        if (state_q != ST_STEER || !flags_q.diff_gt_15_16) begin
            so_d = '0;
        end else if (so_q != SO_MAX) begin
            so_d = so_q + SO_W'(1);
        end
    end

    // Leave on the clock that completes STEP_OFF_CYCLES held clocks.
    assign step_off_c = flags_q.diff_gt_15_16 && (so_q == SO_MAX);
`else
    assign step_off_c = flags_q.diff_gt_15_16;
`endif

    // Next-state logic; if/else order encodes transition priority.
    always_comb begin
        state_d   = state_q;
        clr_tmr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flags_q.sum_gt_min) begin
                    state_d   = ST_WAIT;
                    clr_tmr_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (flags_q.sum_lt_min) begin
                    state_d = ST_IDLE;
                end else if (flags_q.diff_gt_1_4) begin
                    clr_tmr_c = 1'b1;
                end else if (tmr_full_c) begin
                    state_d = ST_STEER;
                end
            end
            ST_STEER: begin
                if (flags_q.sum_lt_min) begin
                    state_d = ST_IDLE;
                end else if (step_off_c) begin
                    state_d   = ST_WAIT;
                    clr_tmr_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settle timer: runs only in WAIT, saturating at its terminal count.
    always_comb begin
        tmr_d = tmr_q;
        if (clr_tmr_c) begin
            tmr_d = '0;
        end else if (state_q == ST_WAIT && !tmr_full_c) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            flags_q <= '0;
            tmr_q   <= '0;
`ifdef STEP_OFF_DLY_EN
            so_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            tmr_q   <= tmr_d;
`ifdef STEP_OFF_DLY_EN
            so_q    <= so_d;
`endif
        end
    end

    // Moore decode straight from the state flop, so reset clears en_steer at once.
    assign bus.en_steer  = (state_q == ST_STEER);
    assign bus.rider_off = (state_q == ST_IDLE);
    assign bus.sm_state  = state_q;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Bench for steer_en_ctrl: directed scenarios with hand-computed timing plus
// a randomized phase, all compared every cycle against a behavioural model.
module tb_steer_en_ctrl;

    localparam int unsigned LD_W = 12;
    localparam int          MIN  = 512;
    localparam int          HYST = 64;
    localparam int          TMR  = 16;
    localparam int          SOC  = 8;

    logic clk = 1'b0;
    logic rst_n;
    bit   cmp_on = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #10 clk = ~clk;

    steer_en_ctrl_if #(.LD_W(LD_W)) bus ();

    steer_en_ctrl #(
        .LD_W            (LD_W),
        .MIN_RIDER_WT    (MIN),
        .HYST            (HYST),
        .TMR_CYCLES      (TMR),
        .STEP_OFF_CYCLES (SOC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model: 0=IDLE 1=WAIT 2=STEER
    int m_state = 0;
    int m_wait  = 0;   // clocks settled in WAIT since last restart, capped
    int m_run   = 0;   // consecutive STEER clocks with severe imbalance
    bit f_gt = 0, f_lt = 0, f_d14 = 0, f_so = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int  sum, diff, lo, nxt, run;
        bit  restart, leave;
        if (!rst_n) begin
            m_state = 0; m_wait = 0; m_run = 0;
            f_gt = 0; f_lt = 0; f_d14 = 0; f_so = 0;
        end else begin
            nxt     = m_state;
            restart = 1'b0;
            run     = (m_state == 2 && f_so) ? m_run + 1 : 0;
`ifdef STEP_OFF_DLY_EN
            leave   = (run >= SOC);
`else
            leave   = f_so;
`endif
            case (m_state)
                0: if (f_gt) begin nxt = 1; restart = 1'b1; end
                1: begin
                    if (f_lt)                nxt = 0;
                    else if (f_d14)          restart = 1'b1;
                    else if (m_wait >= TMR - 1) nxt = 2;
                end
                2: begin
                    if (f_lt)       nxt = 0;
                    else if (leave) begin nxt = 1; restart = 1'b1; end
                end
                default: nxt = 0;
            endcase
            if (restart)            m_wait = 0;
            else if (m_state == 1)  m_wait = (m_wait + 1 > TMR - 1) ? TMR - 1 : m_wait + 1;
            m_run   = run;
            m_state = nxt;
            if (bus.ld_vld) begin
                sum   = int'(bus.lft_ld) + int'(bus.rght_ld);
                diff  = int'(bus.lft_ld) - int'(bus.rght_ld);
                if (diff < 0) diff = -diff;
                lo    = MIN - HYST;
                f_gt  = (sum > MIN + HYST);
                f_lt  = (lo >= 0) && (sum < lo);
                f_d14 = (diff > sum / 4);
                f_so  = (diff > sum - sum / 16);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_sm_state", int'(bus.sm_state), m_state);
            chk("cyc_en_steer", int'(bus.en_steer), int'(m_state == 2));
            chk("cyc_rider_off", int'(bus.rider_off), int'(m_state == 0));
            chk("cyc_exclusive", int'(bus.en_steer && bus.rider_off), 0);
        end
    end

    task automatic strobe(input int l, input int r);
        @(negedge clk);
        bus.lft_ld  = LD_W'(l);
        bus.rght_ld = LD_W'(r);
        bus.ld_vld  = 1'b1;
        @(negedge clk);
        bus.ld_vld  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_sample(output int l, output int r);
        int mode, base, d;
        mode = int'($urandom_range(0, 10));
        if (mode <= 5) begin
            base = int'($urandom_range(180, 420));
            d    = int'($urandom_range(0, 40));
            l = base + d; r = base - d;
        end else if (mode <= 7) begin
            l = int'($urandom_range(500, 1200));
            r = int'($urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1) begin d = l; l = r; r = d; end
        end else if (mode == 8) begin
            l = int'($urandom_range(0, 250));
            r = int'($urandom_range(0, 250));
        end else if (mode == 9) begin
            l = int'($urandom_range(210, 300));
            r = int'($urandom_range(210, 300));
        end else begin
            l = 4095 - int'($urandom_range(0, 3));
            r = 4095 - int'($urandom_range(0, 3));
        end
    endtask

    initial begin
        int l, r;
        bus.lft_ld  = '0;
        bus.rght_ld = '0;
        bus.ld_vld  = 1'b0;
        rst_n       = 1'b0;

        // Reset values
        step(3);
        chk("rst_rider_off", int'(bus.rider_off), 1);
        chk("rst_en_steer", int'(bus.en_steer), 0);
        chk("rst_sm_state", int'(bus.sm_state), 0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        step(1);
        chk("post_rst_rider_off", int'(bus.rider_off), 1);
        chk("post_rst_sm_state", int'(bus.sm_state), 0);

        // Mount: WAIT two clocks after strobe, STEER sixteen clocks later
        strobe(400, 400);
        step(1);
        chk("mount_wait", int'(bus.sm_state), 1);
        step(15);
        chk("mount_still_wait", int'(bus.sm_state), 1);
        step(1);
        chk("mount_steer", int'(bus.sm_state), 2);
        chk("mount_en_steer", int'(bus.en_steer), 1);
        chk("mount_rider_off", int'(bus.rider_off), 0);
        chk("model_mount_steer", m_state, 2);

        // Dismount
        strobe(50, 50);
        chk("dismount_hold", int'(bus.sm_state), 2);
        step(1);
        chk("dismount_idle", int'(bus.sm_state), 0);
        chk("dismount_rider_off", int'(bus.rider_off), 1);

        // Hysteresis about MIN_RIDER_WT
        strobe(288, 288);
        step(3);
        chk("hyst_576_idle", int'(bus.sm_state), 0);
        strobe(289, 288);
        step(1);
        chk("hyst_577_wait", int'(bus.sm_state), 1);
        strobe(224, 224);
        step(1);
        chk("hyst_448_wait", int'(bus.sm_state), 1);
        strobe(224, 223);
        step(1);
        chk("hyst_447_idle", int'(bus.sm_state), 0);
        chk("model_hyst_idle", m_state, 0);

        // Imbalance keeps restarting the settle timer
        strobe(400, 400);
        step(1);
        chk("imbal_wait", int'(bus.sm_state), 1);
        for (int i = 0; i < 10; i++) begin
            strobe(600, 200);
            step(2);
            chk("imbal_no_steer", int'(bus.sm_state == 2'd2), 0);
        end
        strobe(400, 400);
        step(15);
        chk("imbal_bal_wait", int'(bus.sm_state), 1);
        step(1);
        chk("imbal_bal_steer", int'(bus.sm_state), 2);

        // Step-off
        strobe(800, 10);
`ifdef STEP_OFF_DLY_EN
        step(7);
        chk("stepoff_hold7", int'(bus.sm_state), 2);
        step(1);
        chk("stepoff_wait8", int'(bus.sm_state), 1);
`else
        chk("stepoff_hold", int'(bus.sm_state), 2);
        step(1);
        chk("stepoff_wait", int'(bus.sm_state), 1);
`endif
        chk("model_stepoff_wait", m_state, 1);
        strobe(400, 400);
        step(18);
        chk("restore_steer", int'(bus.sm_state), 2);
`ifdef STEP_OFF_DLY_EN
        strobe(800, 10);
        step(5);
        strobe(400, 400);
        step(4);
        chk("stepoff_pulse7_steer", int'(bus.sm_state), 2);
`endif

        // Coincidence: dismount and timer-full on the same clock
        strobe(50, 50);
        step(1);
        chk("coinc_pre_idle", int'(bus.sm_state), 0);
        strobe(400, 400);
        step(14);
        strobe(100, 100);
        chk("coinc_wait_full", int'(bus.sm_state), 1);
        step(1);
        chk("coinc_idle", int'(bus.sm_state), 0);
        chk("model_coinc_idle", m_state, 0);

        // Reset mid-STEER drops en_steer without a clock edge
        strobe(400, 400);
        step(17);
        chk("rst_pre_steer", int'(bus.sm_state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_en_steer", int'(bus.en_steer), 0);
        chk("rst_async_rider_off", int'(bus.rider_off), 1);
        chk("rst_async_sm_state", int'(bus.sm_state), 0);
        step(2);
        rst_n = 1'b1;

        // Randomized phase
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            bus.ld_vld = 1'b0;
            if (c == 1000) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                rand_sample(l, r);
                bus.lft_ld  = LD_W'(l);
                bus.rght_ld = LD_W'(r);
                bus.ld_vld  = 1'b1;
            end
        end
        @(negedge clk);
        bus.ld_vld = 1'b0;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/steer_en_ctrl.md
STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

Interface
REQ-001 SHALL have parameter LD_W, default 12, meaning the width of each load-cell sample.
REQ-002 SHALL have parameter MIN_RIDER_WT, default 12'h200, meaning the rider-present weight threshold.
REQ-003 SHALL have parameter HYST, default 12'h040, meaning the hysteresis applied about MIN_RIDER_WT.
REQ-004 SHALL have parameter TMR_CYCLES, default 65_000_000, meaning the settle time in clocks (1.3 s at 50 MHz).
REQ-005 SHALL have parameter STEP_OFF_CYCLES, default 1_000_000, meaning the step-off persistence in clocks; used only with STEP_OFF_DLY_EN.
REQ-006 SHALL have port clk, input, 1 bit: 50 MHz clock; the only clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port lft_ld, input, LD_W bits: left load-cell sample, unsigned.
REQ-009 SHALL have port rght_ld, input, LD_W bits: right load-cell sample, unsigned.
REQ-010 SHALL have port ld_vld, input, 1 bit: one-cycle strobe marking new samples.
REQ-011 SHALL have port en_steer, output, 1 bit: steering enable to balance control.
REQ-012 SHALL have port rider_off, output, 1 bit: no rider present.
REQ-013 SHALL have port sm_state, output, 2 bits: state code (IDLE=0, WAIT=1, STEER=2).

Function
REQ-014 SHALL compute sum = lft_ld+rght_ld at LD_W+1 bits (no overflow) and diff = |lft_ld-rght_ld|.
REQ-015 SHALL register four flags only on ld_vld cycles (held otherwise), valid the cycle after the strobe.
- sum_gt_min = sum > MIN_RIDER_WT+HYST
- sum_lt_min = sum < MIN_RIDER_WT-HYST, evaluated signed and never true if the threshold is negative
- diff_gt_1_4 = diff > sum>>2
- diff_gt_15_16 = diff > sum-(sum>>4)
REQ-016 SHALL use strict compares; sum exactly at a threshold asserts neither sum flag.
REQ-017 SHALL implement a settle timer that clears to 0 on clr_tmr, otherwise increments in WAIT and saturates at TMR_CYCLES-1; tmr_full is asserted when the count equals TMR_CYCLES-1.
REQ-018 SHALL implement a three-state FSM, IDLE/WAIT/STEER, with the transitions in REQ-019 to REQ-021.
REQ-019 SHALL, in IDLE, go to WAIT with clr_tmr when sum_gt_min, and otherwise stay.
REQ-020 SHALL, in WAIT, evaluate in priority order:
- sum_lt_min: go to IDLE
- diff_gt_1_4: clr_tmr, stay
- tmr_full: go to STEER
- otherwise: stay
REQ-021 SHALL, in STEER, go to IDLE on sum_lt_min (priority), go to WAIT with clr_tmr on step-off per REQ-031 and REQ-032, and otherwise stay.
REQ-022 SHALL decode outputs from the state register only (Moore): rider_off=1 in IDLE, en_steer=1 in STEER, else 0.
REQ-023 SHALL give a latency of 2 clocks from the ld_vld edge to the output change (flag register, then state register).
REQ-024 SHALL take one transition per clock; when events coincide, the REQ-020/REQ-021 priority decides.
REQ-025 SHALL never assert en_steer and rider_off in the same cycle.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, flags 0, timer 0 and step-off counter 0.
REQ-027 SHALL drive outputs during and immediately after reset as rider_off=1, en_steer=0, sm_state=0.
REQ-028 SHALL, on reset mid-STEER, drop en_steer in the same cycle without waiting for a clock.

Configuration
REQ-029 SHALL support the macro STEP_OFF_DLY_EN, which selects the STEER step-off behaviour.
REQ-030 SHALL size the step-off counter for STEP_OFF_CYCLES; it clears whenever diff_gt_15_16=0 or the state is not STEER.
REQ-031 SHALL, with STEP_OFF_DLY_EN defined, leave STEER for WAIT only after diff_gt_15_16 has held for STEP_OFF_CYCLES consecutive clocks.
REQ-032 SHALL, with STEP_OFF_DLY_EN undefined, omit the counter and leave STEER for WAIT on the first clock diff_gt_15_16=1.

Verification
(bench parameters: LD_W=12, MIN_RIDER_WT=512, HYST=64, TMR_CYCLES=16, STEP_OFF_CYCLES=8)
REQ-033 SHALL cover mount: lft=rght=400 strobed -> sm_state=WAIT 2 clocks later, STEER 16 clocks after that, en_steer=1, rider_off=0.
REQ-034 SHALL cover hysteresis: sum=576 (exactly MIN+HYST) -> stays IDLE; sum=577 -> WAIT; from WAIT, sum=448 -> stays WAIT, sum=447 -> IDLE.
REQ-035 SHALL cover imbalance: in WAIT, lft=600, rght=200 (diff 400 > 200) strobed every 4 clocks for 40 clocks -> never STEER; then balanced -> STEER 16 clocks later.
REQ-036 SHALL cover step-off: in STEER, lft=800, rght=10 -> with macro, WAIT after 8 consecutive clocks (pulse of 7 keeps STEER); without macro, WAIT 2 clocks after strobe.
REQ-037 SHALL cover dismount and reset: in STEER, sum=100 -> IDLE with rider_off=1 after 2 clocks; rst_n low mid-STEER -> en_steer=0 immediately.
REQ-038 SHALL cover coincidence: in WAIT, sum_lt_min and tmr_full in the same cycle -> IDLE, never STEER.
